// File: rtl/seg7_pkg.sv
// Shared 7-segment glyph table and decode helper for display driver and scan reader.
// Latency: n/a (constants, types and a pure function).
// Backpressure: n/a.
package seg7_pkg;

  // Segment order {a,b,c,d,e,f,g}, bit 6 = a, active-high.
  localparam logic [6:0] SEG7_0 = 7'h7E;
  localparam logic [6:0] SEG7_1 = 7'h30;
  localparam logic [6:0] SEG7_2 = 7'h6D;
  localparam logic [6:0] SEG7_3 = 7'h79;
  localparam logic [6:0] SEG7_4 = 7'h33;
  localparam logic [6:0] SEG7_5 = 7'h5B;
  localparam logic [6:0] SEG7_6 = 7'h5F;
  localparam logic [6:0] SEG7_7 = 7'h70;
  localparam logic [6:0] SEG7_8 = 7'h7F;
  localparam logic [6:0] SEG7_9 = 7'h7B;
  localparam logic [6:0] SEG7_A = 7'h77;
  localparam logic [6:0] SEG7_B = 7'h1F;
  localparam logic [6:0] SEG7_C = 7'h4E;
  localparam logic [6:0] SEG7_D = 7'h3D;
  localparam logic [6:0] SEG7_E = 7'h4F;
  localparam logic [6:0] SEG7_F = 7'h47;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_HOLD  = 2'd2
  } scan_state_t;

  // Returns {err, value}; patterns outside the glyph table decode to 0 with err set.
  function automatic logic [4:0] seg7_to_hex(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      SEG7_0:  r = {1'b0, 4'h0};
      SEG7_1:  r = {1'b0, 4'h1};
      SEG7_2:  r = {1'b0, 4'h2};
      SEG7_3:  r = {1'b0, 4'h3};
      SEG7_4:  r = {1'b0, 4'h4};
      SEG7_5:  r = {1'b0, 4'h5};
      SEG7_6:  r = {1'b0, 4'h6};
      SEG7_7:  r = {1'b0, 4'h7};
      SEG7_8:  r = {1'b0, 4'h8};
      SEG7_9:  r = {1'b0, 4'h9};
      SEG7_A:  r = {1'b0, 4'hA};
      SEG7_B:  r = {1'b0, 4'hB};
      SEG7_C:  r = {1'b0, 4'hC};
      SEG7_D:  r = {1'b0, 4'hD};
      SEG7_E:  r = {1'b0, 4'hE};
      SEG7_F:  r = {1'b0, 4'hF};
      default: r = {1'b1, 4'h0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Converts one active-high segment pattern to a hex nibble plus illegal-glyph flag.
// Latency: combinational.
// Backpressure: none; pure function of the input.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] value,
  output logic       err
);

  // Single shared table lookup so driver and reader can never disagree.
  assign {err, value} = seg7_to_hex(seg);

endmodule

// File: rtl/seg7_scan_reader.sv
// Rebuilds a multi-digit hex frame from scanned 7-segment lines, capturing each digit once it is stable.
// Latency: pin change to capture STABLE_CYCLES+1 cycles; last capture to frame_valid 1 cycle.
// Backpressure: none; frame_valid is a one-cycle pulse and digits hold until the next frame.
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8,
  parameter bit SEG_ACT_LOW   = 1'b0,
  parameter bit AN_ACT_LOW    = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_valid,
  output logic                    scan_err
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

  logic [NUM_DIGITS-1:0]   an_fix, an_q, an_p;
  logic [6:0]              seg_fix, seg_q, seg_p;
  scan_state_t             state;
  logic [CW-1:0]           cnt;
  logic [NUM_DIGITS-1:0]   mask;
  logic [4*NUM_DIGITS-1:0] stg_val;
  logic [NUM_DIGITS-1:0]   stg_err;
  logic [3:0]              dec_val;
  logic                    dec_err;
  logic                    same, an_oh, an_multi, capture, complete;

  assign an_fix  = AN_ACT_LOW  ? ~an  : an;
  assign seg_fix = SEG_ACT_LOW ? ~seg : seg;

  // Register the pins once, and keep the previous sample for the stability comparison.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_q  <= '0;
      seg_q <= '0;
      an_p  <= '0;
      seg_p <= '0;
    end else begin
      an_q  <= an_fix;
      seg_q <= seg_fix;
      an_p  <= an_q;
      seg_p <= seg_q;
    end
  end

  seg7_glyph_decode u_dec (
    .seg   (seg_q),
    .value (dec_val),
    .err   (dec_err)
  );

  assign same     = (an_q == an_p) && (seg_q == seg_p);
  assign an_oh    = (an_q != '0) && ((an_q & (an_q - AN_ONE)) == '0);
  assign an_multi = (an_q != '0) && !an_oh;
  // Capture on the cycle the identical-sample run reaches STABLE_CYCLES.
  assign capture  = (state == ST_TRACK) && same && (cnt == CW'(STABLE_CYCLES - 1));
  assign complete = &mask;

  // Scan FSM, stability counter, staging slots and frame publication.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      mask        <= '0;
      stg_val     <= '0;
      stg_err     <= '0;
      digits      <= '0;
      digit_err   <= '0;
      frame_valid <= 1'b0;
      scan_err    <= 1'b0;
    end else begin
      if (an_multi) scan_err <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (an_oh) begin
            state <= ST_TRACK;
            cnt   <= CW'(1);
          end
        end
        ST_TRACK: begin
          if (same) begin
            if (cnt == CW'(STABLE_CYCLES - 1)) state <= ST_HOLD;
            if (cnt != CW'(STABLE_CYCLES)) cnt <= cnt + CW'(1);
          end else if (an_oh) begin
            cnt <= CW'(1);
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (!same) begin
            if (an_oh) begin
              state <= ST_TRACK;
              cnt   <= CW'(1);
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Latest capture wins within a frame; a capture on the completion cycle starts the next frame.
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (capture && an_q[k]) begin
          stg_val[4*k +: 4] <= dec_val;
          stg_err[k]        <= dec_err;
        end
      end
      mask <= (complete ? '0 : mask) | (capture ? an_q : '0);

      frame_valid <= complete;
      if (complete) begin
        digits    <= stg_val;
        digit_err <= stg_err;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Bench for seg7_scan_reader: table of full scans plus hand sequences for glitch, multi-hot and reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_seg7_scan_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        scan_err;

  always #5 clk = ~clk;

  seg7_scan_reader #(
    .NUM_DIGITS(4), .STABLE_CYCLES(8), .SEG_ACT_LOW(1'b0), .AN_ACT_LOW(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .seg(seg), .an(an), .digits(digits),
    .digit_err(digit_err), .frame_valid(frame_valid), .scan_err(scan_err)
  );

  typedef struct {
    logic [6:0]  sg [4];
    int          hold [4];
    logic [15:0] ed;
    logic [3:0]  ee;
    bit          fr;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  e;
  } exp_t;

  vec_t vt [9];
  exp_t sbq [$];
  exp_t got;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int idx);
    if (vt[idx].fr) sbq.push_back('{d: vt[idx].ed, e: vt[idx].ee});
    for (int d = 0; d < 4; d++) drive(4'(1 << d), vt[idx].sg[d], vt[idx].hold[d]);
    if (vt[idx].fr) chk($sformatf("v%0d_frame_arrived", idx), sbq.size(), 0);
  endtask

  // Scoreboard: every frame_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_frame: got digits %0h err %0h expected no frame", digits, digit_err);
      end else begin
        got = sbq.pop_front();
        chk("frame_digits", 32'(digits), 32'(got.d));
        chk("frame_err", 32'(digit_err), 32'(got.e));
      end
    end
  end

  initial begin
    vt[0] = '{sg: '{7'h7E, 7'h30, 7'h6D, 7'h79}, hold: '{20, 20, 20, 20}, ed: 16'h3210, ee: 4'b0000, fr: 1'b1};
    vt[1] = '{sg: '{7'h7E, 7'h30, 7'h6D, 7'h79}, hold: '{20, 20, 20, 20}, ed: 16'h3210, ee: 4'b0000, fr: 1'b1};
    vt[2] = '{sg: '{7'h77, 7'h1F, 7'h4E, 7'h3D}, hold: '{20, 20, 20, 20}, ed: 16'hDCBA, ee: 4'b0000, fr: 1'b1};
    vt[3] = '{sg: '{7'h4F, 7'h47, 7'h7F, 7'h7B}, hold: '{20, 20, 20, 20}, ed: 16'h98FE, ee: 4'b0000, fr: 1'b1};
    vt[4] = '{sg: '{7'h33, 7'h5B, 7'h5F, 7'h70}, hold: '{20, 20, 20, 20}, ed: 16'h7654, ee: 4'b0000, fr: 1'b1};
    vt[5] = '{sg: '{7'h7E, 7'h01, 7'h6D, 7'h79}, hold: '{20, 20, 20, 20}, ed: 16'h3200, ee: 4'b0010, fr: 1'b1};
    vt[6] = '{sg: '{7'h77, 7'h30, 7'h5B, 7'h79}, hold: '{20, 20, 5, 20},  ed: 16'h0000, ee: 4'b0000, fr: 1'b0};
    vt[7] = '{sg: '{7'h5F, 7'h70, 7'h7F, 7'h7B}, hold: '{20, 20, 20, 20}, ed: 16'h9876, ee: 4'b0000, fr: 1'b1};
    vt[8] = '{sg: '{7'h4E, 7'h3D, 7'h4F, 7'h47}, hold: '{20, 20, 20, 20}, ed: 16'hFEDC, ee: 4'b0000, fr: 1'b1};

    // Reset held with toggling pins: everything stays at zero.
    reset = 1'b1;
    an    = '0;
    seg   = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      an  = 4'($urandom);
      seg = 7'($urandom);
      @(negedge clk);
      chk($sformatf("rst%0d_digits", i), 32'(digits), 32'h0);
      chk($sformatf("rst%0d_err", i), 32'(digit_err), 32'h0);
      chk($sformatf("rst%0d_fv", i), 32'(frame_valid), 32'h0);
      chk($sformatf("rst%0d_scan_err", i), 32'(scan_err), 32'h0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(4'b0000, 7'h00, 3);

    // Full scans, repeated scan, all glyphs, illegal glyph.
    for (int v = 0; v <= 5; v++) run_vec(v);
    chk("scan_err_clean", 32'(scan_err), 32'h0);

    // Digit 2 held too briefly: no frame until digit 2 alone is held long enough.
    run_vec(6);
    chk("glitch_no_frame", 32'(frame_valid), 32'h0);
    sbq.push_back('{d: 16'h351A, e: 4'b0000});
    drive(4'b0100, 7'h5B, 20);
    chk("glitch_recover_arrived", sbq.size(), 0);

    // Multi-hot enable: sticky scan_err, then a normal scan still frames.
    drive(4'b0011, 7'h7E, 3);
    chk("multihot_scan_err", 32'(scan_err), 32'h1);
    run_vec(7);
    chk("scan_err_sticky", 32'(scan_err), 32'h1);

    // Reset after three captures discards the partial frame.
    drive(4'b0001, 7'h5B, 20);
    drive(4'b0010, 7'h33, 20);
    drive(4'b0100, 7'h70, 20);
    reset = 1'b1;
    drive(4'b0100, 7'h70, 2);
    reset = 1'b0;
    chk("midrst_digits", 32'(digits), 32'h0);
    chk("midrst_scan_err", 32'(scan_err), 32'h0);
    chk("midrst_fv", 32'(frame_valid), 32'h0);
    run_vec(8);

    drive(4'b0000, 7'h00, 5);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
